serial_add_sub: RTL and testbench

Parametrised bit-serial adder/subtractor: the sequential successor to the single-bit full adder and full subtractor cells. One full-adder slice and a carry flip-flop process one bit per clock, LSB first, over WIDTH-bit operands. A mode input selects A+B or A−B (two's complement: B inverted, carry seeded to 1). Start/busy/done handshake; result, carry-out and signed overflow are held until the next operation.

---
 rtl/serial_add_sub.sv | 134 +++++++++++++
 tb/tb_serial_add_sub.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Bit-serial adder/subtractor. A single full-adder slice and a carry flip-flop
// walk the two operands LSB first, one bit per clock, so a WIDTH-bit operation
// takes WIDTH cycles after it is accepted. Subtraction reuses the same slice by
// inverting B and seeding the carry with 1 (two's complement).
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset, priority over everything else
//   start     request an operation; only honoured while idle
//   mode      0 = a + b, 1 = a - b; captured together with start
//   a, b      WIDTH-bit operands; captured together with start
//   busy      high while an operation is in progress
//   done      one-cycle pulse when result/c_out/overflow become valid
//   result    sum or difference modulo 2^WIDTH (meaningful while busy = 0)
//   c_out     carry out of the MSB; for subtract 1 means no borrow (a >= b)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CW-1:0]    count;

  logic             sum_bit;
  logic             carry_next;
  logic             last_step;

  // The single full-adder slice working on the current LSBs of the operand
  // shift registers. last_step marks the MSB position, where carry and
  // carry_next are exactly the carry into and out of the MSB.
  always_comb begin
    sum_bit    = sa[0] ^ sb[0] ^ carry;
    carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    last_step  = (count == CW'(WIDTH - 1));
  end

  // Next-state logic: a start is only looked at in IDLE, so a start that
  // arrives while running is simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = RUN;
      RUN:     if (last_step) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign busy = (state == RUN);

  // Datapath. On acceptance the operands are captured (B pre-inverted for
  // subtract, carry seeded with mode). Each RUN cycle retires one bit into
  // the top of the result register, so after WIDTH steps the LSB has drifted
  // down to bit 0. c_out and overflow are only written on the MSB step so
  // they keep the previous operation's values while a new one is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      carry    <= 1'b0;
      count    <= '0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= mode ? ~b : b;
            carry <= mode;
            count <= '0;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          carry  <= carry_next;
          result <= {sum_bit, result[WIDTH-1:1]};
          if (last_step) begin
            count    <= '0;
            c_out    <= carry_next;
            overflow <= carry ^ carry_next;
            done     <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//
// Drives three builds of serial_add_sub (WIDTH = 8, 2 and 32) side by side.
// A timeline model computes the arithmetic from plain integer maths and tracks
// when each operation is accepted and when its done pulse is due; a single
// negedge process compares every DUT against that model on every cycle.
// Directed vectors additionally pin results to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

  localparam int W0 = 8;
  localparam int W1 = 2;
  localparam int W2 = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0]       st = '0;
  logic [2:0]       md = '0;
  logic [2:0][31:0] av = '0;
  logic [2:0][31:0] bv = '0;

  logic busy8, busy2, busy32;
  logic done8, done2, done32;
  logic cout8, cout2, cout32;
  logic ovf8, ovf2, ovf32;
  logic [W0-1:0] res8;
  logic [W1-1:0] res2;
  logic [W2-1:0] res32;

  logic [2:0]       busy_o;
  logic [2:0]       done_o;
  logic [2:0]       cout_o;
  logic [2:0]       ovf_o;
  logic [2:0][31:0] res_o;

  assign busy_o = {busy32, busy2, busy8};
  assign done_o = {done32, done2, done8};
  assign cout_o = {cout32, cout2, cout8};
  assign ovf_o  = {ovf32, ovf2, ovf8};
  assign res_o  = {32'(res32), 32'(res2), 32'(res8)};

  int wd [3] = '{W0, W1, W2};

  int nTests = 0;
  int nFail  = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(W0)) u_dut8 (
    .clk(clk), .rst(rst), .start(st[0]), .mode(md[0]),
    .a(av[0][W0-1:0]), .b(bv[0][W0-1:0]),
    .busy(busy8), .done(done8), .result(res8), .c_out(cout8), .overflow(ovf8)
  );

  serial_add_sub #(.WIDTH(W1)) u_dut2 (
    .clk(clk), .rst(rst), .start(st[1]), .mode(md[1]),
    .a(av[1][W1-1:0]), .b(bv[1][W1-1:0]),
    .busy(busy2), .done(done2), .result(res2), .c_out(cout2), .overflow(ovf2)
  );

  serial_add_sub #(.WIDTH(W2)) u_dut32 (
    .clk(clk), .rst(rst), .start(st[2]), .mode(md[2]),
    .a(av[2]), .b(bv[2]),
    .busy(busy32), .done(done32), .result(res32), .c_out(cout32), .overflow(ovf32)
  );

  // Reference arithmetic: returns {overflow, c_out, result}. Overflow is
  // judged by doing the operation on the signed values and asking whether the
  // true answer fits in w bits.
  function automatic logic [33:0] arith(int w, logic m, logic [31:0] x, logic [31:0] y);
    longint mask, half, ua, ub, full, sx, sy, sr;
    logic   co, ov;
    mask = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ua   = longint'(x) & mask;
    ub   = longint'(y) & mask;
    full = m ? ua + ((~ub & mask) + 1) : ua + ub;
    co   = ((full >>> w) & 1) != 0;
    sx   = (ua >= half) ? ua - (mask + 1) : ua;
    sy   = (ub >= half) ? ub - (mask + 1) : ub;
    sr   = m ? sx - sy : sx + sy;
    ov   = (sr < -half) || (sr >= half);
    return {ov, co, 32'(full & mask)};
  endfunction

  task automatic checkOutput(input string name, input int w,
                             input logic [33:0] got, input logic [33:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s (W=%0d): got %0h, expected %0h", name, w, got, exp);
    end
  endtask

  // Timeline model: cyc numbers the rising edges. An operation accepted on
  // edge k completes on edge k+W; a start is only accepted when no operation
  // is outstanding; reset wipes everything.
  logic [31:0]      cyc = '0;
  logic [2:0]       m_run = '0;
  logic [2:0]       m_done = '0;
  logic [2:0][31:0] m_acc = '0;
  logic [2:0][33:0] m_pend = '0;
  logic [2:0][33:0] m_out = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_run[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        m_out[i]  <= '0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_run[i]) begin
          if (cyc == m_acc[i] + 32'(wd[i])) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
            m_out[i]  <= m_pend[i];
          end
        end else if (st[i]) begin
          m_run[i]  <= 1'b1;
          m_acc[i]  <= cyc;
          m_pend[i] <= arith(wd[i], md[i], av[i], bv[i]);
        end
      end
    end
  end

  // Every-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("busy", wd[i], 34'(busy_o[i]), 34'(m_run[i]));
        checkOutput("done", wd[i], 34'(done_o[i]), 34'(m_done[i]));
        if (!m_run[i]) begin
          checkOutput("result", wd[i], 34'(res_o[i]), 34'(m_out[i][31:0]));
          checkOutput("c_out", wd[i], 34'(cout_o[i]), 34'(m_out[i][32]));
          checkOutput("overflow", wd[i], 34'(ovf_o[i]), 34'(m_out[i][33]));
        end
      end
    end
  end

  // Issue one operation (called at a negedge) and wait, bounded, for done.
  // Operands and mode are scrambled mid-run to show they are not re-sampled.
  task automatic applyStimulus(input int i, input logic m, input logic [31:0] x,
                               input logic [31:0] y, output int lat);
    int cnt;
    cnt = 0;
    lat = -1;
    st[i] = 1'b1;
    md[i] = m;
    av[i] = x;
    bv[i] = y;
    while (cnt < wd[i] + 4) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) st[i] = 1'b0;
      if (cnt == 2) begin
        md[i] = 1'($urandom);
        av[i] = $urandom;
        bv[i] = $urandom;
      end
      if (done_o[i]) begin
        lat = cnt - 1;
        break;
      end
    end
    if (lat < 0) checkOutput("done timeout", wd[i], 34'(0), 34'(1));
  endtask

  initial begin
    int lat, cnt, d1, d2;
    bit sawDone;
    logic [33:0] exp;

    // Reset
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset busy", W0, 34'(busy8), 34'(0));
    checkOutput("reset done", W0, 34'(done8), 34'(0));
    checkOutput("reset outputs", W0, {ovf8, cout8, 32'(res8)}, 34'(0));
    rst = 1'b0;
    @(negedge clk);

    // Pin the model to hand-computed answers
    checkOutput("model 3C+05", W0, arith(8, 1'b0, 32'h3C, 32'h05), {2'b00, 32'h41});
    checkOutput("model FF+01", W0, arith(8, 1'b0, 32'hFF, 32'h01), {2'b01, 32'h00});
    checkOutput("model 7F+01", W0, arith(8, 1'b0, 32'h7F, 32'h01), {2'b10, 32'h80});
    checkOutput("model 05-07", W0, arith(8, 1'b1, 32'h05, 32'h07), {2'b00, 32'hFE});
    checkOutput("model 80-01", W0, arith(8, 1'b1, 32'h80, 32'h01), {2'b11, 32'h7F});

    // Directed vectors on the 8-bit build
    applyStimulus(0, 1'b0, 32'h3C, 32'h05, lat);
    checkOutput("latency 3C+05", W0, 34'(lat), 34'(8));
    checkOutput("dut 3C+05", W0, {ovf8, cout8, 32'(res8)}, {2'b00, 32'h41});
    @(negedge clk);
    checkOutput("done single pulse", W0, 34'(done8), 34'(0));
    applyStimulus(0, 1'b0, 32'hFF, 32'h01, lat);
    checkOutput("dut FF+01", W0, {ovf8, cout8, 32'(res8)}, {2'b01, 32'h00});
    applyStimulus(0, 1'b0, 32'h7F, 32'h01, lat);
    checkOutput("dut 7F+01", W0, {ovf8, cout8, 32'(res8)}, {2'b10, 32'h80});
    applyStimulus(0, 1'b1, 32'h05, 32'h07, lat);
    checkOutput("dut 05-07", W0, {ovf8, cout8, 32'(res8)}, {2'b00, 32'hFE});
    applyStimulus(0, 1'b1, 32'h80, 32'h01, lat);
    checkOutput("dut 80-01", W0, {ovf8, cout8, 32'(res8)}, {2'b11, 32'h7F});
    checkOutput("latency 80-01", W0, 34'(lat), 34'(8));

    // Start pulses during RUN are ignored
    st[0] = 1'b1; md[0] = 1'b0; av[0] = 32'h12; bv[0] = 32'h34;
    cnt = 0; lat = -1;
    while (cnt < 14) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1 || cnt == 4 || cnt == 6) st[0] = 1'b0;
      if (cnt == 3 || cnt == 5) begin
        st[0] = 1'b1; md[0] = 1'b1; av[0] = 32'hFF; bv[0] = 32'h01;
      end
      if (done8) begin lat = cnt - 1; break; end
    end
    checkOutput("latency ignore-start", W0, 34'(lat), 34'(8));
    checkOutput("dut ignore-start", W0, {ovf8, cout8, 32'(res8)}, {2'b00, 32'h46});

    // Start held high through done: the second op is taken from the done cycle
    st[0] = 1'b1; md[0] = 1'b0; av[0] = 32'h10; bv[0] = 32'h20;
    cnt = 0; d1 = -1; d2 = -1;
    while (cnt < 30 && d2 < 0) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin av[0] = 32'h50; bv[0] = 32'h60; end
      if (d1 >= 0 && cnt == d1 + 1) st[0] = 1'b0;
      if (done8) begin
        if (d1 < 0) begin
          d1 = cnt;
          checkOutput("dut b2b first", W0, {ovf8, cout8, 32'(res8)}, {2'b00, 32'h30});
        end else begin
          d2 = cnt;
          checkOutput("dut b2b second", W0, {ovf8, cout8, 32'(res8)}, {2'b10, 32'hB0});
        end
      end
    end
    st[0] = 1'b0;
    checkOutput("b2b done spacing", W0, 34'(d2 - d1), 34'(W0 + 1));

    // Reset in the middle of a RUN aborts it
    st[0] = 1'b1; md[0] = 1'b0; av[0] = 32'h55; bv[0] = 32'h22;
    repeat (4) begin
      @(negedge clk);
      st[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", W0, 34'(busy8), 34'(0));
    checkOutput("abort done", W0, 34'(done8), 34'(0));
    checkOutput("abort outputs", W0, {ovf8, cout8, 32'(res8)}, 34'(0));
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) sawDone = 1'b1;
    end
    checkOutput("no done after abort", W0, 34'(sawDone), 34'(0));

    // Exhaustive 2-bit build
    for (int m = 0; m < 2; m++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++) begin
          applyStimulus(1, 1'(m), 32'(x), 32'(y), lat);
          exp = arith(2, 1'(m), 32'(x), 32'(y));
          checkOutput("exhaustive", W1, {ovf2, cout2, 32'(res2)}, exp);
          checkOutput("latency", W1, 34'(lat), 34'(W1));
        end

    // Random 8-bit and 32-bit vectors
    for (int n = 0; n < 200; n++) begin
      logic m; logic [31:0] x, y;
      m = 1'($urandom); x = $urandom; y = $urandom;
      applyStimulus(0, m, x, y, lat);
      checkOutput("random", W0, {ovf8, cout8, 32'(res8)}, arith(8, m, x, y));
    end
    for (int n = 0; n < 1000; n++) begin
      logic m; logic [31:0] x, y;
      m = 1'($urandom); x = $urandom; y = $urandom;
      applyStimulus(2, m, x, y, lat);
      checkOutput("random", W2, {ovf32, cout32, res32}, arith(32, m, x, y));
      checkOutput("latency", W2, 34'(lat), 34'(W2));
    end

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
